// File: rtl/alu_mc.sv
// alu_mc: ALU with valid/ready handshake; single-cycle logic/arith ops, iterative shift-add MUL.
// Define ALU_MC_DIV_EN to build in the unsigned restoring divider for opcode 111.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, acc, mq;
  logic [6:0]       cnt;
  logic             accept, iter_op, last_iter;
  logic [WIDTH-1:0] simple_lo, step_acc, step_mq;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_MC_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   div_sh;
`endif

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == ITER);
  assign last_iter = (cnt == 7'(WIDTH - 1));

  always_comb begin
    iter_op = (alu_control == 3'b101);
`ifdef ALU_MC_DIV_EN
    iter_op = iter_op || (alu_control == 3'b111);
`endif
  end

  always_comb begin
    simple_lo = '0;
    case (alu_control)
      3'b000:  simple_lo = op1 & op2;
      3'b001:  simple_lo = op1 | op2;
      3'b010:  simple_lo = op1 + op2;
      3'b011:  simple_lo = WIDTH'(op1 < op2);
      3'b100:  simple_lo = op1 - op2;
      3'b110:  simple_lo = WIDTH'($signed(op1) < $signed(op2));
      default: simple_lo = '0;
    endcase
  end

  // acc:mq is the double-width working register; MUL shifts right, DIV shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    step_acc = mul_sum[WIDTH:1];
    step_mq  = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    div_sh = {acc, mq[WIDTH-1]};
    if (is_div) begin
      if (div_sh >= {1'b0, mcand}) begin
        step_acc = WIDTH'(div_sh - {1'b0, mcand});
        step_mq  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_sh[WIDTH-1:0];
        step_mq  = {mq[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = iter_op ? ITER : DONE;
      ITER:    if (last_iter) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = iter_op ? ITER : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mq     <= '0;
      cnt    <= '0;
      result <= '0;
      hi     <= '0;
`ifdef ALU_MC_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (accept) begin
      cnt <= '0;
      if (iter_op) begin
        acc <= '0;
`ifdef ALU_MC_DIV_EN
        is_div <= (alu_control == 3'b111);
        // DIV keeps the divisor in mcand and shifts the dividend out of mq.
        mcand  <= (alu_control == 3'b111) ? op2 : op1;
        mq     <= (alu_control == 3'b111) ? op1 : op2;
`else
        mcand <= op1;
        mq    <= op2;
`endif
      end else begin
        result <= simple_lo;
        hi     <= '0;
      end
    end else if (state == ITER) begin
      acc <= step_acc;
      mq  <= step_mq;
      cnt <= cnt + 7'd1;
      if (last_iter) begin
        result <= step_mq;
        hi     <= step_acc;
      end
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request operands/opcode present.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port op1  input  WIDTH  first operand.
REQ-007 SHALL have port op2  input  WIDTH  second operand.
REQ-008 SHALL have port alu_control  input  3  opcode.
REQ-009 SHALL have port out_valid  output  1  result/hi valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH  primary result (low product, quotient).
REQ-012 SHALL have port hi  output  WIDTH  secondary result (high product, remainder; else 0).
REQ-013 SHALL have port busy  output  1  high in ITER state.

Function
REQ-014 SHALL accept a request on the cycle in_valid && in_ready, capturing op1, op2, alu_control.
REQ-015 SHALL decode: 000 AND, 001 OR, 010 ADD, 011 SLTU, 100 SUB, 101 MUL, 110 SLT (signed), 111 DIV (see Configuration).
REQ-016 SHALL use FSM states IDLE, ITER, DONE; IDLE->DONE for single-cycle ops, IDLE->ITER for MUL/DIV, ITER->DONE after WIDTH iterations, DONE->IDLE on out_ready without new accept.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), allowing back-to-back accept on the completing cycle.
REQ-018 SHALL assert out_valid exactly in DONE; single-cycle ops latency 1 cycle from accept; MUL/DIV latency WIDTH+1 cycles.
REQ-019 SHALL hold result, hi, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH, carry/borrow discarded; hi=0.
REQ-021 SHALL compute SLT as signed two's-complement op1<op2, SLTU unsigned, result 1 or 0 zero-extended; hi=0.
REQ-022 SHALL compute MUL unsigned via iterative shift-add, one op2 bit per cycle; {hi,result} = full 2*WIDTH product.
REQ-023 SHALL ignore in_valid while in ITER or in DONE with out_ready low (in_ready=0).
REQ-024 SHALL keep result/hi unchanged in IDLE (last delivered values).

Reset
REQ-025 SHALL on rst_n low, immediately: state=IDLE, result=0, hi=0, out_valid=0, busy=0, iteration counter=0.
REQ-026 SHALL abort any in-flight MUL/DIV on reset with no output produced; in_ready=1 after deassertion.

Configuration
REQ-027 SHALL use macro ALU_MC_DIV_EN to compile divider in or out.
REQ-028 SHALL with ALU_MC_DIV_EN defined implement opcode 111 as unsigned restoring division, WIDTH iterations; result=quotient, hi=remainder.
REQ-029 SHALL with ALU_MC_DIV_EN defined and op2==0 return result=all ones, hi=op1, same latency WIDTH+1.
REQ-030 SHALL without ALU_MC_DIV_EN treat opcode 111 as single-cycle op returning result=0, hi=0, no divider logic present.

Verification
REQ-031 SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid 1 cycle later, result=0, hi=0.
REQ-032 SHALL cover: SLT op1=0xFFFFFFFF, op2=1 -> result=1; SLTU same operands -> result=0.
REQ-033 SHALL cover: MUL 0xFFFFFFFF*0xFFFFFFFF -> out_valid after 33 cycles, busy high 32 cycles, hi=0xFFFFFFFE, result=0x00000001.
REQ-034 SHALL cover: out_ready held low 5 cycles after AND 0xF0F0,0xFF00 -> result=0xF000 stable, in_ready=0; raise out_ready with in_valid OR 1,2 -> both accepted back-to-back, next result=3.
REQ-035 SHALL cover: rst_n low at cycle 10 of MUL -> out_valid=0, result=0 immediately; new ADD 2+3 after release -> result=5.
REQ-036 SHALL cover: ALU_MC_DIV_EN defined, DIV 100/7 -> result=14, hi=2; DIV 5/0 -> result=0xFFFFFFFF, hi=5; undefined -> opcode 111 gives result=0 after 1 cycle.
